// File: rtl/div_recon_mul.sv
// ---------------------------------------------------------------------------
// div_recon_mul
//
// Sequential shift-add reconstruction multiplier. It rebuilds the dividend of
// a 16/8 array divider as p = q*y + r and flags whether it equals x_ref.
//
// The low APPROX_COLS accumulator columns can optionally be approximated the
// way the dividers approximate their low-order cells. Partial-product bits
// below that column are dropped, and no carry leaves the masked region. The
// final remainder add is always exact.
//
// Parameters
//   APPROX_COLS : 0..4, number of pass-through LSB columns (0 = exact)
//
// Ports
//   clk        : single clock, rising edge
//   rst        : asynchronous, active-high reset
//   in_valid   : operand set valid
//   in_ready   : block can accept operands (IDLE only)
//   q          : 8-bit quotient (multiplier)
//   y          : 8-bit divisor (multiplicand)
//   r          : 8-bit remainder (added exactly)
//   x_ref      : 16-bit original dividend for the comparison
//   out_valid  : result valid, held until out_ready
//   out_ready  : downstream accepts the result
//   p          : 16-bit reconstructed dividend
//   match      : p == x_ref, meaningful while out_valid is high
// ---------------------------------------------------------------------------
module div_recon_mul #(
    parameter int APPROX_COLS = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  q,
    input  logic [7:0]  y,
    input  logic [7:0]  r,
    input  logic [15:0] x_ref,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] p,
    output logic        match
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADDR = 2'd2,
        DONE = 2'd3
    } state_t;

    // Columns at or above APPROX_COLS take part in the partial-product add.
    localparam logic [15:0] COL_MASK = 16'hFFFF << APPROX_COLS;

    // Column-masked add. The masked operands have zero low bits, so the
    // upper sum cannot receive a carry from the pass-through columns. The
    // pass-through columns keep the accumulator's own bits.
    function automatic logic [15:0] masked_add(input logic [15:0] acc_v,
                                               input logic [15:0] pp_v);
        logic [15:0] hi_sum;
        hi_sum     = (acc_v & COL_MASK) + (pp_v & COL_MASK);
        masked_add = (hi_sum & COL_MASK) | (acc_v & ~COL_MASK);
    endfunction

    state_t      state_r;
    state_t      state_s;

    logic [7:0]  q_r;
    logic [7:0]  y_r;
    logic [7:0]  r_r;
    logic [15:0] x_ref_r;
    logic [15:0] acc_r;
    logic [2:0]  cnt_r;
    logic [15:0] p_r;
    logic        match_r;
    logic        out_valid_r;

    logic [15:0] pp_s;
    logic [15:0] final_sum_s;

    // Partial product for the current multiplier bit and the exact final sum.
    always_comb begin
        pp_s        = 16'h0000;
        final_sum_s = acc_r + {8'h00, r_r};
        if (q_r[cnt_r]) begin
            pp_s = {8'h00, y_r} << cnt_r;
        end else begin
            pp_s = 16'h0000;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s = MUL;
                end else begin
                    state_s = IDLE;
                end
            end
            MUL: begin
                if (cnt_r == 3'd7) begin
                    state_s = ADDR;
                end else begin
                    state_s = MUL;
                end
            end
            ADDR: begin
                state_s = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Operand capture, accumulation and registered result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r         <= 8'h00;
            y_r         <= 8'h00;
            r_r         <= 8'h00;
            x_ref_r     <= 16'h0000;
            acc_r       <= 16'h0000;
            cnt_r       <= 3'd0;
            p_r         <= 16'h0000;
            match_r     <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        q_r     <= q;
                        y_r     <= y;
                        r_r     <= r;
                        x_ref_r <= x_ref;
                        acc_r   <= 16'h0000;
                        cnt_r   <= 3'd0;
                    end
                end
                MUL: begin
                    acc_r <= masked_add(acc_r, pp_s);
                    // Wraps back to 0 after the last bit.
                    cnt_r <= cnt_r + 3'd1;
                end
                ADDR: begin
                    acc_r       <= final_sum_s;
                    p_r         <= final_sum_s;
                    match_r     <= (final_sum_s == x_ref_r);
                    out_valid_r <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign out_valid = out_valid_r;
    assign p         = p_r;
    assign match     = match_r;

endmodule
